// File: rtl/digit_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl_if
//  Description : Bundle between the display value registers (master) and the
//                digit scanner (slave).
//                master -> slave : enable, digits_in, dp_in, blank_mask
//                slave -> master : ct, digit, nibble, dp, frame_tick
//  Revision    : 1.0 - initial release
// ============================================================================
interface digit_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int c_DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   ct;
    logic [c_DIGIT_W-1:0]    digit;
    logic [3:0]              nibble;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output enable, digits_in, dp_in, blank_mask,
        input  ct, digit, nibble, dp, frame_tick
    );

    modport slave (
        input  enable, digits_in, dp_in, blank_mask,
        output ct, digit, nibble, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl
//  Description : Time-multiplexed N-digit display scanner. Drives one
//                active-low digit enable at a time for CLK_DIV cycles per
//                slot, blanked for the first DEAD_CYCLES of every slot.
//                The digit values are snapshotted at each frame start so a
//                frame never mixes old and new values.
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous, active-high reset
//                bus.slave  - enable/digits_in/dp_in/blank_mask in,
//                             ct/digit/nibble/dp/frame_tick out (registered)
//  Options     : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//                (index > 0, no dp) are kept dark, judged on the snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  wire              clk,
    input  wire              reset,
    digit_scan_ctrl_if.slave bus
);
    localparam int c_DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_DIGIT_W-1:0] c_DIG_MAX = c_DIGIT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_DIGIT_W-1:0]    r_digit;
    logic [4*NUM_DIGITS-1:0] r_snap_nib;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_ct;
    logic [3:0]              r_nibble;
    logic                    r_dp;
    logic                    r_frame_tick;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_DIGIT_W-1:0]    w_digit_nxt;
    logic [4*NUM_DIGITS-1:0] w_snap_nib_nxt;
    logic [NUM_DIGITS-1:0]   w_snap_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_ct_nxt;
    logic [3:0]              w_nibble_nxt;
    logic                    w_dp_nxt;
    logic                    w_tick_nxt;
    logic                    w_in_blank;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [NUM_DIGITS-1:0]   w_mask;

    // ------------------------------------------------------------------
    // Slot timing: counter, digit index, snapshot and frame tick
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_digit_nxt    = r_digit;
        w_snap_nib_nxt = r_snap_nib;
        w_snap_dp_nxt  = r_snap_dp;
        w_tick_nxt     = 1'b0;

        if (!bus.enable) begin
            // Disable aborts the frame outright; no partial frame tick.
            w_cnt_nxt   = '0;
            w_digit_nxt = '0;
        end else if (r_state == S_IDLE) begin
            // Scan starts at slot 0 with a fresh snapshot on the same edge.
            w_cnt_nxt      = '0;
            w_digit_nxt    = '0;
            w_snap_nib_nxt = bus.digits_in;
            w_snap_dp_nxt  = bus.dp_in;
        end else if (r_cnt == c_CNT_MAX) begin
            w_cnt_nxt = '0;
            if (r_digit == c_DIG_MAX) begin
                w_digit_nxt    = '0;
                w_tick_nxt     = 1'b1;
                w_snap_nib_nxt = bus.digits_in;
                w_snap_dp_nxt  = bus.dp_in;
            end else begin
                w_digit_nxt = r_digit + 1'b1;
            end
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Dead-time window; with no dead time the blank phase never exists.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign w_in_blank = 1'b0;
        end else begin : g_dead
            assign w_in_blank = (w_cnt_nxt < c_CNT_W'(DEAD_CYCLES));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Leading-zero suppression, judged on the frame snapshot only
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic w_zero_run;
        w_lz       = '0;
        w_zero_run = 1'b1;
        // Walk from the most significant digit down; digit 0 is never blanked.
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run && (r_snap_nib[i*4 +: 4] == 4'd0);
            w_lz[i]    = w_zero_run && !r_snap_dp[i];
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_mask = bus.blank_mask | w_lz;

    // ------------------------------------------------------------------
    // FSM next state and registered output values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_ct_nxt     = '1;
        w_nibble_nxt = w_snap_nib_nxt[{w_digit_nxt, 2'b00} +: 4];
        w_dp_nxt     = w_snap_dp_nxt[w_digit_nxt];

        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
        end else if (w_in_blank) begin
            w_state_nxt = S_BLANK;
        end else begin
            w_state_nxt = S_ON;
        end

        // Only one bit can ever be cleared, so digits never overlap.
        if ((w_state_nxt == S_ON) && !w_mask[w_digit_nxt]) begin
            w_ct_nxt[w_digit_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_snap_nib   <= '0;
            r_snap_dp    <= '0;
            r_ct         <= '1;
            r_nibble     <= 4'd0;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_snap_nib   <= w_snap_nib_nxt;
            r_snap_dp    <= w_snap_dp_nxt;
            r_ct         <= w_ct_nxt;
            r_nibble     <= w_nibble_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_tick <= w_tick_nxt;
        end
    end

    assign bus.ct         = r_ct;
    assign bus.digit      = r_digit;
    assign bus.nibble     = r_nibble;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_ctrl
//  Description : Self-checking bench for digit_scan_ctrl (4 digits, 8 clk per
//                slot, 2 dead cycles). A frame-position reference model checks
//                every cycle; a vector table and short sequences cover the
//                documented corner cases, followed by random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    digit_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    digit_scan_ctrl #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (frame position based) ----------------
    bit         m_run = 1'b0;
    int         m_p   = 0;        // cycles since scan start
    logic [3:0] m_nib [N];
    logic       m_dp  [N];
    logic [3:0] e_ct;
    int         e_dig;
    logic       e_tick;
    logic [3:0] e_nib;
    logic       e_dp;

    function automatic bit lz_dark(int d);
        if (!LZ || d == 0) return 1'b0;
        for (int j = d; j < N; j++)
            if (m_nib[j] != 4'd0) return 1'b0;
        return !m_dp[d];
    endfunction

    function automatic void capture();
        for (int i = 0; i < N; i++) begin
            m_nib[i] = bus.digits_in[i*4 +: 4];
            m_dp[i]  = bus.dp_in[i];
        end
    endfunction

    function automatic void model_edge();
        int cnt;
        if (!bus.enable) begin
            m_run = 1'b0;
            m_p   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_p   = 0;
            capture();
        end else begin
            m_p++;
            if (m_p % FRAME == 0) capture();
        end
        if (!m_run) begin
            e_ct = 4'hF; e_dig = 0; e_tick = 1'b0;
        end else begin
            cnt    = m_p % DIV;
            e_dig  = (m_p / DIV) % N;
            e_tick = (m_p > 0) && (m_p % FRAME == 0);
            e_nib  = m_nib[e_dig];
            e_dp   = m_dp[e_dig];
            e_ct   = 4'hF;
            if (cnt >= DEAD && !bus.blank_mask[e_dig] && !lz_dark(e_dig))
                e_ct[e_dig] = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("ct", 32'(bus.ct), 32'(e_ct));
        chk("digit", 32'(bus.digit), 32'(e_dig));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        if (m_run) begin
            chk("nibble", 32'(bus.nibble), 32'(e_nib));
            chk("dp", 32'(bus.dp), 32'(e_dp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step_to(input int p);
        for (int k = 0; k < FRAME * 2 && m_p < p; k++) step();
        chk("reach_pos", 32'(m_p), 32'(p));
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mk);
        bus.enable = 1'b0;
        step();
        bus.digits_in  = d;
        bus.dp_in      = dpv;
        bus.blank_mask = mk;
        bus.enable     = 1'b1;
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpv;
        logic [3:0]  mask;
        int          slot;
        logic [3:0]  exp_ct;
        logic [3:0]  exp_nib;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [14];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 0, 4'b1110, 4'h4, 1'b0};
        vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 1, 4'b1101, 4'h3, 1'b0};
        vecs[2]  = '{16'h1234, 4'b0000, 4'b0000, 2, 4'b1011, 4'h2, 1'b0};
        vecs[3]  = '{16'h1234, 4'b0000, 4'b0000, 3, 4'b0111, 4'h1, 1'b0};
        vecs[4]  = '{16'h1234, 4'b0000, 4'b0010, 1, 4'b1111, 4'h3, 1'b0};
        vecs[5]  = '{16'h1234, 4'b0000, 4'b0010, 2, 4'b1011, 4'h2, 1'b0};
        vecs[6]  = '{16'h1234, 4'b0101, 4'b0000, 2, 4'b1011, 4'h2, 1'b1};
        vecs[7]  = '{16'h1234, 4'b0101, 4'b0000, 1, 4'b1101, 4'h3, 1'b0};
        vecs[8]  = '{16'h0045, 4'b0000, 4'b0000, 3, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b0};
        vecs[9]  = '{16'h0045, 4'b0000, 4'b0000, 2, LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b0};
        vecs[10] = '{16'h0045, 4'b0000, 4'b0000, 1, 4'b1101, 4'h4, 1'b0};
        vecs[11] = '{16'h0045, 4'b0100, 4'b0000, 2, 4'b1011, 4'h0, 1'b1};
        vecs[12] = '{16'h0045, 4'b0100, 4'b0000, 3, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b0};
        vecs[13] = '{16'h0000, 4'b0000, 4'b0000, 0, 4'b1110, 4'h0, 1'b0};

        bus.enable     = 1'b0;
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.blank_mask = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ct", 32'(bus.ct), 32'hF);
        chk("rst_digit", 32'(bus.digit), 0);
        chk("rst_nibble", 32'(bus.nibble), 0);
        chk("rst_dp", 32'(bus.dp), 0);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors: blank phase then last ON cycle of the chosen slot
        foreach (vecs[i]) begin
            restart(vecs[i].digits, vecs[i].dpv, vecs[i].mask);
            step_to(vecs[i].slot * DIV + DEAD - 1);
            chk("vec_blank_ct", 32'(bus.ct), 32'hF);
            step_to(vecs[i].slot * DIV + DIV - 1);
            chk("vec_ct", 32'(bus.ct), 32'(vecs[i].exp_ct));
            chk("vec_nibble", 32'(bus.nibble), 32'(vecs[i].exp_nib));
            chk("vec_dp", 32'(bus.dp), 32'(vecs[i].exp_dp));
        end

        // No tearing: change value during slot 1
        restart(16'h1234, 4'b0000, 4'b0000);
        step_to(10);
        bus.digits_in = 16'h5678;
        step_to(23);
        chk("tear_slot2", 32'(bus.nibble), 32'h2);
        step_to(31);
        chk("tear_slot3", 32'(bus.nibble), 32'h1);
        step_to(32);
        chk("tear_tick", 32'(bus.frame_tick), 1);
        step_to(39);
        chk("new_slot0", 32'(bus.nibble), 32'h8);
        step_to(47);
        chk("new_slot1", 32'(bus.nibble), 32'h7);

        // Abort mid-slot 2 (counter 5), then restart
        restart(16'h1234, 4'b0000, 4'b0000);
        step_to(21);
        bus.enable = 1'b0;
        step();
        chk("abort_ct", 32'(bus.ct), 32'hF);
        chk("abort_digit", 32'(bus.digit), 0);
        chk("abort_tick", 32'(bus.frame_tick), 0);
        bus.enable = 1'b1;
        step();
        chk("reen_digit", 32'(bus.digit), 0);
        chk("reen_ct", 32'(bus.ct), 32'hF);
        for (int k = 1; k < FRAME; k++) begin
            step();
            chk("reen_no_tick", 32'(bus.frame_tick), 0);
        end
        step();
        chk("reen_tick", 32'(bus.frame_tick), 1);

        // Asynchronous reset mid-scan
        step_to(FRAME + 13);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ct", 32'(bus.ct), 32'hF);
        chk("async_digit", 32'(bus.digit), 0);
        chk("async_tick", 32'(bus.frame_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        m_run = 1'b0;
        m_p   = 0;

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) bus.enable = ~bus.enable;
            else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
            if ($urandom_range(0, 9) == 0) bus.digits_in = 16'($urandom);
            if ($urandom_range(0, 9) == 0) bus.digits_in = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) bus.dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) bus.blank_mask = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
